subtractor_div_ctrl: RTL and testbench
======================================

# subtractor_div_ctrl

Sequential controller that performs unsigned 8-bit restoring division by time-multiplexing one instance of the team's combinational `subtractor` (A, B, Diff, Borrow) over eight iterations. It sits beside the ALU datapath as the multi-cycle DIV/MOD unit. It accepts operands through a start/busy/done handshake and returns quotient, remainder and a divide-by-zero flag.

## Interface
Parameters:
- none. The width is fixed at 8 bits to match the `subtractor` instance.

Ports (clock: single clock `clk`; reset: `rst_n`, synchronous, active-low):
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge
- `start`  in  1  request; sampled only in IDLE
- `dividend`  in  8  unsigned dividend, captured on accept
- `divisor`  in  8  unsigned divisor, captured on accept
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse; results valid while high and held afterwards
- `quotient`  out  8  unsigned quotient
- `remainder`  out  8  unsigned remainder
- `div_by_zero`  out  1  set with `done` when the captured divisor was 0

## Operation
- Internal registers:
  - `R[7:0]`: partial remainder
  - `Q[7:0]`: dividend shift register that becomes the quotient
  - `D[7:0]`: latched divisor
  - `cnt[3:0]`: iteration counter
  - FSM state
- One `subtractor` instance:
  - A = {R[6:0], Q[7]}, the shifted partial remainder.
  - B = D.
- States:
  - IDLE: `busy`=0. If `start`=1:
    - Capture Q←dividend, D←divisor, R←0, cnt←0.
    - If divisor=0, go to DONE with the zero-divide result.
    - Otherwise go to CALC.
  - CALC: one iteration per cycle.
    - If Borrow=0: R←Diff and shift 1 into Q, i.e. Q←{Q[6:0],1}.
    - If Borrow=1: R←{R[6:0],Q[7]} and Q←{Q[6:0],0}.
    - cnt←cnt+1.
    - After the iteration with cnt=7, go to DONE.
  - DONE: `done`=1 for exactly this one cycle, then return to IDLE unconditionally.
- Outputs:
  - `quotient` = Q and `remainder` = R. Both are registered and hold their last value until the next accept or reset.
- Arithmetic fact: R is never larger than the dividend prefix consumed so far, and that prefix is at most 127 before the final shift. The shifted value {R[6:0],Q[7]} is therefore always exact in 8 bits, and no 9th bit is needed.
- Divide by zero (detected in IDLE at accept):
  - Set Q←8'hFF, R←dividend, `div_by_zero`←1.
  - Go directly to DONE without entering CALC.
- `div_by_zero` is cleared on the next accept.
- `start` while busy, including the DONE cycle, is ignored and not queued.
- Operand changes after accept have no effect.

## Timing
- Reset (`rst_n`=0 at an edge), from any state:
  - state←IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, cnt=0.
  - A reset in the middle of CALC abandons the operation; no `done` is produced.
- Normal division, with accept at edge k:
  - `busy`=1 from after edge k.
  - Iterations occur on edges k+1 … k+8.
  - `done`=1 during the cycle after edge k+8.
  - The back-to-IDLE edge is k+9.
  - Latency is 9 cycles from accept to `done`, and the next accept is possible at edge k+10.
- Divide by zero, with accept at edge k: `done`=1 during the cycle after edge k; IDLE again at edge k+1.
- `start` held high continuously produces back-to-back operations every 10 cycles (normal) or every 2 cycles (zero divisor).
- `start` and `rst_n`=0 at the same edge: reset wins and nothing is accepted.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges, then release -> all outputs 0 and `busy`=0; `start`=0 for 5 cycles keeps IDLE.
- Directed divisions, checking `done` exactly 9 cycles after accept and `div_by_zero`=0:
  - 200/7 -> q=28, r=4.
  - 255/1 -> q=255, r=0.
  - 5/10 -> q=0, r=5.
  - 255/255 -> q=1, r=0.
  - 0/3 -> q=0, r=0.
  - 255/129 -> q=1, r=126.
- Zero divisor: 200/0 -> `done` and `div_by_zero`=1 one cycle after accept, q=8'hFF, r=200. Then 10/3 -> q=3, r=1, `div_by_zero`=0.
- Busy handling: pulse `start` with 9/2 during CALC and during DONE of a 100/9 operation -> only 100/9 completes (q=11, r=1), with exactly one `done` pulse.
- Reset mid-operation: accept 200/7, drive `rst_n`=0 at iteration 4 -> IDLE, outputs 0, no `done`. A fresh 200/7 then completes correctly.
- Exhaustive sweep of all 65536 operand pairs against a reference model: q = a/b, r = a%b, plus the zero-divisor rule.

Source files
------------

// File: rtl/subtractor_div_ctrl.sv
// Multi-cycle unsigned 8-bit restoring divider (DIV/MOD unit).
// One shared combinational subtractor is reused for eight iterations per operation.

module subtractor (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on accept
// CALC  | one shift/subtract iteration per cycle, eight in total
// DONE  | done pulse for one cycle, results valid
module subtractor_div_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] r_q, q_q, d_q;
  logic [3:0] cnt;
  logic       dbz;
  logic [7:0] shifted;
  logic [7:0] diff;
  logic       borrow;
  logic       accept;

  // The shifted partial remainder always fits in 8 bits for restoring division.
  assign shifted = {r_q[6:0], q_q[7]};
  assign accept  = (state == IDLE) && start;

  subtractor u_sub (
    .a      (shifted),
    .b      (d_q),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == 8'd0) ? DONE : CALC;
      CALC: if (cnt == 4'd7) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 8'd0;
      q_q <= 8'd0;
      d_q <= 8'd0;
      cnt <= 4'd0;
      dbz <= 1'b0;
    end else if (accept) begin
      cnt <= 4'd0;
      d_q <= divisor;
      if (divisor == 8'd0) begin
        q_q <= 8'hFF;
        r_q <= dividend;
        dbz <= 1'b1;
      end else begin
        q_q <= dividend;
        r_q <= 8'd0;
        dbz <= 1'b0;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 4'd1;
      if (!borrow) begin
        r_q <= diff;
        q_q <= {q_q[6:0], 1'b1};
      end else begin
        r_q <= shifted;
        q_q <= {q_q[6:0], 1'b0};
      end
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz;
endmodule

// File: tb/tb_subtractor_div_ctrl.sv
// Scoreboard bench for subtractor_div_ctrl: the driver queues expected results,
// the monitor checks them (and their timing) whenever done is seen.

module tb_subtractor_div_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_done = 0;

  subtractor_div_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("done_latency", cyc - e.acc, e.z ? 0 : 8);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Issue one operation at a negedge; accept happens at the following edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.acc = cyc + 1;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom_range(255));
    divisor  = 8'($urandom_range(255));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    int acc;
    logic [7:0] corner [5];
    corner[0] = 8'd0; corner[1] = 8'd1; corner[2] = 8'd127;
    corner[3] = 8'd128; corner[4] = 8'd255;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset");
    repeat (5) @(negedge clk);
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_done_count", n_done, 0);

    // Directed divisions
    issue(8'd200, 8'd7);
    issue(8'd255, 8'd1);
    issue(8'd5,   8'd10);
    issue(8'd255, 8'd255);
    issue(8'd0,   8'd3);
    issue(8'd255, 8'd129);

    // Zero divisor, then a normal op clears the flag
    issue(8'd200, 8'd0);
    issue(8'd10,  8'd3);
    wait_idle();

    // Start ignored during CALC and DONE
    issue(8'd100, 8'd9);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    while (!done && busy) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_ignored_queue", sb.size(), 0);
    chk("busy_ignored_idle", busy, 0);

    // Reset wins over a simultaneous start
    start = 1'b1; dividend = 8'd5; divisor = 8'd1; rst_n = 1'b0;
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    check_reset_outputs("rst_vs_start");

    // Reset in the middle of CALC abandons the operation
    issue(8'd200, 8'd7);
    acc = sb[sb.size()-1].acc;
    while (cyc < acc + 3) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("mid_reset");
    repeat (10) @(negedge clk);
    chk("mid_reset_stays_idle", busy, 0);
    issue(8'd200, 8'd7);

    // Corner cross plus random sample against the / and % reference
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        issue(corner[i], corner[j]);
    for (int k = 0; k < 200; k++)
      issue(8'($urandom_range(255)), 8'($urandom_range(255)));

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
